multi_edge_detector: RTL and testbench

Parametrised, multi-channel successor to the single-bit edge detector. Each channel synchronises an asynchronous input, rejects glitches shorter than a programmable number of cycles, and emits a one-cycle pulse on rising, falling or both edges according to a per-channel mode. It also keeps a sticky write-1-to-clear flag per channel. It sits between raw pins or cross-domain strobes and the control logic that consumes single-cycle events.

---
 rtl/multi_edge_detector.sv | 74 +++++++
 tb/tb_multi_edge_detector.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// Per-channel synchroniser, glitch filter and edge pulser with a sticky write-1-to-clear flag.
// Latency is SYNC_STAGES+FILTER_CYCLES edges from input to level/edge_pulse. There is no backpressure: every accepted edge pulses once.
module multi_edge_detector #(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     flag_clr,
    output logic [WIDTH-1:0]     level,
    output logic [WIDTH-1:0]     edge_pulse,
    output logic [WIDTH-1:0]     edge_flag,
    output logic                 edge_any
);

    localparam int              CW       = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0][SYNC_STAGES-1:0] sync_q;
    logic [WIDTH-1:0][CW-1:0]          cnt_q;
    logic [WIDTH-1:0][CW-1:0]          cnt_nxt;
    logic [WIDTH-1:0]                  s;
    logic [WIDTH-1:0]                  level_nxt;
    logic [WIDTH-1:0]                  pulse_nxt;
    logic [WIDTH-1:0]                  flag_nxt;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // A differing level must be seen for FILTER_CYCLES consecutive cycles; any return to level restarts the count.
    always_comb begin
        level_nxt = level;
        pulse_nxt = '0;
        cnt_nxt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] != level[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_nxt[i] = s[i];
                    pulse_nxt[i] = s[i] ? mode[2*i] : mode[2*i+1];
                end else begin
                    cnt_nxt[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        flag_nxt = (edge_flag & ~flag_clr) | pulse_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            level      <= '0;
            edge_pulse <= '0;
            edge_flag  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], in[i]};
            end
            cnt_q      <= cnt_nxt;
            level      <= level_nxt;
            edge_pulse <= pulse_nxt;
            edge_flag  <= flag_nxt;
        end
    end

    assign edge_any = |edge_pulse;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector with default parameters (4 channels, 5-edge latency).
module tb_multi_edge_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_r;
    logic [7:0] mode;
    logic [3:0] flag_clr;
    logic [3:0] level;
    logic [3:0] edge_pulse;
    logic [3:0] edge_flag;
    logic       edge_any;

    int checks = 0;
    int errors = 0;

    multi_edge_detector #(.WIDTH(4), .SYNC_STAGES(2), .FILTER_CYCLES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in_r),
        .mode       (mode),
        .flag_clr   (flag_clr),
        .level      (level),
        .edge_pulse (edge_pulse),
        .edge_flag  (edge_flag),
        .edge_any   (edge_any)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one channel bit per cycle; bit k of each vector applies to the k-th edge.
    task automatic drive_seq(input string tag, input int ch, input int n,
                             input logic [31:0] ins, input logic [31:0] pul, input logic [31:0] lvl);
        for (int k = 0; k < n; k++) begin
            in_r[ch] = ins[k];
            tick();
            chk($sformatf("%s_pulse%0d", tag, k), 32'(edge_pulse[ch]), 32'(pul[k]));
            chk($sformatf("%s_level%0d", tag, k), 32'(level[ch]), 32'(lvl[k]));
        end
    endtask

    // All channels: pulse pattern expected exactly at the fifth edge, nothing around it.
    task automatic all_seq(input string tag, input logic [3:0] exp_pulse);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("%s_pulse%0d", tag, k), 32'(edge_pulse), (k == 4) ? 32'(exp_pulse) : 32'd0);
            chk($sformatf("%s_any%0d", tag, k), 32'(edge_any), (k == 4) ? 32'(|exp_pulse) : 32'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_r     = 4'hF;
        mode     = 8'b01_01_01_01;
        flag_clr = 4'h0;

        // Reset held 3 cycles with inputs high
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_level%0d", k), 32'(level), 32'd0);
            chk($sformatf("rst_pulse%0d", k), 32'(edge_pulse), 32'd0);
            chk($sformatf("rst_flag%0d", k), 32'(edge_flag), 32'd0);
            chk($sformatf("rst_any%0d", k), 32'(edge_any), 32'd0);
            tick();
        end
        rst = 1'b0;
        all_seq("rel", 4'hF);
        chk("rel_level", 32'(level), 32'hF);
        chk("rel_flag", 32'(edge_flag), 32'hF);

        flag_clr = 4'hF;
        tick();
        flag_clr = 4'h0;
        chk("clr_all", 32'(edge_flag), 32'h0);

        // Falling edges with rising-only mode: level drops, no pulse
        in_r = 4'h0;
        all_seq("fall01", 4'h0);
        chk("fall01_level", 32'(level), 32'h0);

        // Basic latency on ch0: 8 cycles high then low
        mode = 8'b01_11_11_01;
        drive_seq("lat", 0, 20, 32'h000FF, 32'h00010, 32'h00FF0);

        // Glitch rejection on ch1: 2-cycle excursion rejected, 3-cycle accepted
        drive_seq("gl2", 1, 10, 32'h003, 32'h000, 32'h000);
        drive_seq("gl3", 1, 12, 32'h007, 32'h090, 32'h070);

        // Mode sweep on ch2: one 10-cycle period per mode
        mode[5:4] = 2'b00;
        drive_seq("m00", 2, 10, 32'h01F, 32'h000, 32'h1F0);
        mode[5:4] = 2'b01;
        drive_seq("m01", 2, 10, 32'h01F, 32'h010, 32'h1F0);
        mode[5:4] = 2'b10;
        drive_seq("m10", 2, 10, 32'h01F, 32'h200, 32'h1F0);
        mode[5:4] = 2'b11;
        drive_seq("m11", 2, 10, 32'h01F, 32'h210, 32'h1F0);

        // Sticky flag on ch3: set with the pulse, clear 4 cycles later
        mode[7:6] = 2'b01;
        drive_seq("fl_rise", 3, 5, 32'h1F, 32'h10, 32'h10);
        chk("fl_set", 32'(edge_flag[3]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl_hold%0d", k), 32'(edge_flag[3]), 32'd1);
        end
        flag_clr = 4'b1000;
        tick();
        flag_clr = 4'h0;
        chk("fl_cleared", 32'(edge_flag[3]), 32'd0);

        // Clear coinciding with the pulse edge: set wins
        mode[7:6] = 2'b11;
        drive_seq("fl_fall", 3, 4, 32'h0, 32'h0, 32'hF);
        flag_clr = 4'b1000;
        tick();
        flag_clr = 4'h0;
        chk("fl_win_pulse", 32'(edge_pulse[3]), 32'd1);
        chk("fl_win_flag", 32'(edge_flag[3]), 32'd1);
        chk("fl_win_level", 32'(level[3]), 32'd0);
        tick();
        chk("fl_after_pulse", 32'(edge_pulse[3]), 32'd0);
        chk("fl_after_flag", 32'(edge_flag[3]), 32'd1);

        // Concurrency: all channels rise together, both-edge mode
        mode = 8'hFF;
        in_r = 4'hF;
        all_seq("conc", 4'hF);
        chk("conc_level", 32'(level), 32'hF);

        // Asynchronous reset mid-operation, then input held high through release
        in_r = 4'h0;
        #2 rst = 1'b1;
        #1;
        chk("arst_level", 32'(level), 32'h0);
        chk("arst_flag", 32'(edge_flag), 32'h0);
        chk("arst_pulse", 32'(edge_pulse), 32'h0);
        in_r = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        all_seq("rel2", 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
